user_pixel_stats: RTL and testbench

Downstream consumer of the OBI streamer's pixel output. It accepts 32-bit words of four 8-bit pixels qualified by a valid strobe, and accumulates per-frame statistics over a programmed number of words: sum, minimum, maximum, and the count of pixels at or above a threshold. At frame end it pulses `done_o` and holds the results stable until the next frame starts. Both the frame setup inputs and the results are plain signals, driven by and read by the user-domain controller.

---
 rtl/user_pixel_pkg.sv | 16 +
 rtl/user_pixel_word_stats.sv | 31 +++
 rtl/user_pixel_stats.sv | 119 +++++++++++
 tb/tb_user_pixel_stats.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/user_pixel_pkg.sv
// Shared types and constants for the user-domain pixel statistics block.
package user_pixel_pkg;

  localparam int unsigned PixelWidth    = 8;
  localparam int unsigned PixelsPerWord = 4;

  localparam logic [PixelWidth-1:0] MinInit = 8'hFF;
  localparam logic [PixelWidth-1:0] MaxInit = 8'h00;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } stats_state_e;

endpackage

// File: rtl/user_pixel_word_stats.sv
// Per-word reduction of four pixels: sum, min, max and count at/above threshold.
// Purely combinational; zero latency, no flow control.
module user_pixel_word_stats
  import user_pixel_pkg::*;
(
  input  logic [PixelsPerWord*PixelWidth-1:0] pixels,
  input  logic [PixelWidth-1:0]               thresh,
  output logic [9:0]                          word_sum,
  output logic [PixelWidth-1:0]               word_min,
  output logic [PixelWidth-1:0]               word_max,
  output logic [2:0]                          word_above
);

  logic [PixelWidth-1:0] pix;

  always_comb begin
    word_sum   = '0;
    word_min   = MinInit;
    word_max   = MaxInit;
    word_above = '0;
    pix        = '0;
    for (int k = 0; k < PixelsPerWord; k++) begin
      pix      = pixels[k*PixelWidth +: PixelWidth];
      word_sum = word_sum + {2'b00, pix};
      if (pix < word_min) word_min = pix;
      if (pix > word_max) word_max = pix;
      if (pix >= thresh) word_above = word_above + 3'd1;
    end
  end

endmodule

// File: rtl/user_pixel_stats.sv
// Per-frame pixel statistics over a programmed word count; one word folded in per valid edge.
// Never stalls the source; results are the accumulator registers and hold from done until next start.
module user_pixel_stats
  import user_pixel_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumWordsWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [NumWordsWidth-1:0] num_words_i,
  input  logic [7:0]               thresh_i,
  input  logic [DataWidth-1:0]     pixels_i,
  input  logic                     valid_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              sum_o,
  output logic [7:0]               min_o,
  output logic [7:0]               max_o,
  output logic [23:0]              above_o
);

  stats_state_e           state_q;
  logic [NumWordsWidth-1:0] num_words_q;
  logic [NumWordsWidth-1:0] cnt_q;
  logic [NumWordsWidth-1:0] cnt_nxt;
  logic [7:0]             thresh_q;
  logic [31:0]            sum_q;
  logic [7:0]             min_q;
  logic [7:0]             max_q;
  logic [23:0]            above_q;
  logic                   busy_q;
  logic                   done_q;

  logic [9:0]             word_sum;
  logic [7:0]             word_min;
  logic [7:0]             word_max;
  logic [2:0]             word_above;

  user_pixel_word_stats u_word_stats (
    .pixels     (pixels_i),
    .thresh     (thresh_q),
    .word_sum   (word_sum),
    .word_min   (word_min),
    .word_max   (word_max),
    .word_above (word_above)
  );

  assign cnt_nxt = cnt_q + {{(NumWordsWidth-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      num_words_q <= '0;
      cnt_q       <= '0;
      thresh_q    <= '0;
      sum_q       <= '0;
      min_q       <= MinInit;
      max_q       <= MaxInit;
      above_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            num_words_q <= num_words_i;
            thresh_q    <= thresh_i;
            cnt_q       <= '0;
            sum_q       <= '0;
            min_q       <= MinInit;
            max_q       <= MaxInit;
            above_q     <= '0;
            busy_q      <= 1'b1;
            // An empty frame skips straight to DONE with the empty-frame signature.
            if (num_words_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (valid_i) begin
            sum_q   <= sum_q + {22'd0, word_sum};
            above_q <= above_q + {21'd0, word_above};
            if (word_min < min_q) min_q <= word_min;
            if (word_max > max_q) max_q <= word_max;
            cnt_q   <= cnt_nxt;
            if (cnt_nxt == num_words_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign above_o = above_q;

endmodule

// File: tb/tb_user_pixel_stats.sv
// Directed bench for user_pixel_stats: inputs driven and outputs checked 1ns after each rising edge.
module tb_user_pixel_stats;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] num_words_i;
  logic [7:0]  thresh_i;
  logic [31:0] pixels_i;
  logic        valid_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] sum_o;
  logic [7:0]  min_o;
  logic [7:0]  max_o;
  logic [23:0] above_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  user_pixel_stats #(
    .DataWidth     (32),
    .NumWordsWidth (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .num_words_i (num_words_i),
    .thresh_i    (thresh_i),
    .pixels_i    (pixels_i),
    .valid_i     (valid_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sum_o       (sum_o),
    .min_o       (min_o),
    .max_o       (max_o),
    .above_o     (above_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic done,
                         input logic [31:0] sum, input logic [7:0] mn,
                         input logic [7:0] mx, input logic [23:0] above);
    chk({tag, ".busy"},  {31'd0, busy_o}, {31'd0, busy});
    chk({tag, ".done"},  {31'd0, done_o}, {31'd0, done});
    chk({tag, ".sum"},   sum_o, sum);
    chk({tag, ".min"},   {24'd0, min_o}, {24'd0, mn});
    chk({tag, ".max"},   {24'd0, max_o}, {24'd0, mx});
    chk({tag, ".above"}, {8'd0, above_o}, {8'd0, above});
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    num_words_i = '0;
    thresh_i    = '0;
    pixels_i    = '0;
    valid_i     = 1'b0;
    step(); step();
    chk_all("reset", 1'b0, 1'b0, 32'd0, 8'hFF, 8'h00, 24'd0);
    rst_ni = 1'b1;
    step();

    // Single word frame
    start_i = 1'b1; num_words_i = 16'd1; thresh_i = 8'd3;
    step();
    start_i = 1'b0;
    chk_all("single.start", 1'b1, 1'b0, 32'd0, 8'hFF, 8'h00, 24'd0);
    valid_i = 1'b1; pixels_i = 32'h04030201;
    step();
    valid_i = 1'b0;
    chk_all("single.done", 1'b1, 1'b1, 32'd10, 8'd1, 8'd4, 24'd2);
    step();
    chk_all("single.after", 1'b0, 1'b0, 32'd10, 8'd1, 8'd4, 24'd2);

    // Gapped frame; valid in the start cycle and a start pulse mid-frame are ignored
    start_i = 1'b1; num_words_i = 16'd3; thresh_i = 8'h80;
    valid_i = 1'b1; pixels_i = 32'hFFFFFFFF;
    step();
    start_i = 1'b0; valid_i = 1'b0;
    chk_all("gap.start", 1'b1, 1'b0, 32'd0, 8'hFF, 8'h00, 24'd0);
    step();
    valid_i = 1'b1; pixels_i = 32'h10101010;
    step();
    valid_i = 1'b0;
    start_i = 1'b1; num_words_i = 16'd1; thresh_i = 8'h00;
    step();
    start_i = 1'b0;
    step();
    valid_i = 1'b1; pixels_i = 32'h00FF0080;
    step();
    valid_i = 1'b0;
    chk_all("gap.word2", 1'b1, 1'b0, 32'd447, 8'd0, 8'hFF, 24'd2);
    step();
    valid_i = 1'b1; pixels_i = 32'h01010101;
    step();
    valid_i = 1'b0;
    chk_all("gap.done", 1'b1, 1'b1, 32'd451, 8'd0, 8'hFF, 24'd2);
    step();

    // Valid in IDLE has no effect; results hold
    valid_i = 1'b1; pixels_i = 32'h05050505;
    step(); step(); step();
    valid_i = 1'b0;
    chk_all("idle.hold", 1'b0, 1'b0, 32'd451, 8'd0, 8'hFF, 24'd2);

    // Zero length frame
    start_i = 1'b1; num_words_i = 16'd0; thresh_i = 8'd1;
    step();
    start_i = 1'b0;
    chk_all("zero.done", 1'b1, 1'b1, 32'd0, 8'hFF, 8'h00, 24'd0);
    step();
    chk_all("zero.after", 1'b0, 1'b0, 32'd0, 8'hFF, 8'h00, 24'd0);

    // Reset after 2 of 5 words
    start_i = 1'b1; num_words_i = 16'd5; thresh_i = 8'd1;
    step();
    start_i = 1'b0;
    valid_i = 1'b1; pixels_i = 32'h02020202;
    step(); step();
    valid_i = 1'b0;
    chk_all("midrst.partial", 1'b1, 1'b0, 32'd16, 8'd2, 8'd2, 24'd8);
    rst_ni = 1'b0;
    #2;
    chk_all("midrst.reset", 1'b0, 1'b0, 32'd0, 8'hFF, 8'h00, 24'd0);
    step();
    rst_ni = 1'b1;
    step();
    chk_all("midrst.idle", 1'b0, 1'b0, 32'd0, 8'hFF, 8'h00, 24'd0);
    start_i = 1'b1; num_words_i = 16'd1; thresh_i = 8'h50;
    step();
    start_i = 1'b0;
    valid_i = 1'b1; pixels_i = 32'h64C8320A;
    step();
    valid_i = 1'b0;
    chk_all("midrst.frame", 1'b1, 1'b1, 32'd360, 8'd10, 8'd200, 24'd2);
    step();

    // Full-scale frame, valid every cycle
    start_i = 1'b1; num_words_i = 16'hFFFF; thresh_i = 8'hFF;
    step();
    start_i = 1'b0;
    valid_i = 1'b1; pixels_i = 32'hFFFFFFFF;
    for (int i = 0; i < 65534; i++) step();
    chk("full.not_done_early", {31'd0, done_o}, 32'd0);
    step();
    valid_i = 1'b0;
    chk_all("full.done", 1'b1, 1'b1, 32'd66845700, 8'hFF, 8'hFF, 24'd262140);
    step();
    chk_all("full.after", 1'b0, 1'b0, 32'd66845700, 8'hFF, 8'hFF, 24'd262140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
